// File: rtl/dff_write_arbiter_if.sv
// Requester-side bundle for the shared-register write arbiter: write requests,
// clear request, grants, completion pulses and status.
interface dff_write_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);

  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] wdata_i;
  logic                  clr_i;
  logic [NREQ-1:0]       gnt_o;
  logic [NREQ-1:0]       ack_o;
  logic                  clr_ack_o;
  logic                  busy_o;
  logic                  err_o;

  modport master (
    output req_i,
    output wdata_i,
    output clr_i,
    input  gnt_o,
    input  ack_o,
    input  clr_ack_o,
    input  busy_o,
    input  err_o
  );

  modport slave (
    input  req_i,
    input  wdata_i,
    input  clr_i,
    output gnt_o,
    output ack_o,
    output clr_ack_o,
    output busy_o,
    output err_o
  );

endinterface

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter/sequencer for the shared sync_reset register: grants one
// requester per 3-cycle slot, drives d/srst, and verifies the readback one cycle later.
module dff_write_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  dff_write_arbiter_if.slave       bus,
  input  logic [WIDTH-1:0]         q_i,
  output logic [WIDTH-1:0]         d_o,
  output logic                     srst_o
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    CHECK  = 3'd2,
    CLEAR  = 3'd3,
    CLRCHK = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic              srst_q, srst_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              clr_ack_q, clr_ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              arb_found_c;
  logic [PTR_W-1:0]  arb_idx_c;

  // (base + off) mod NREQ for operands below 2*NREQ
  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned base,
                                                input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // Round-robin search starting at ptr_q
  always_comb begin
    logic [PTR_W-1:0] cand;
    arb_found_c = 1'b0;
    arb_idx_c   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = wrap_idx(32'(ptr_q), i);
      if (!arb_found_c && bus.req_i[cand]) begin
        arb_found_c = 1'b1;
        arb_idx_c   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is the registered copy
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    d_d       = d_q;
    srst_d    = 1'b0;
    gnt_d     = gnt_q;
    ack_d     = '0;
    clr_ack_d = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.clr_i) begin
          state_d = CLEAR;
          srst_d  = 1'b1;
        end else if (arb_found_c) begin
          state_d          = GRANT;
          win_d            = arb_idx_c;
          gnt_d            = '0;
          gnt_d[arb_idx_c] = 1'b1;
          d_d              = bus.wdata_i[32'(arb_idx_c) * WIDTH +: WIDTH];
        end
      end
      GRANT: begin
        state_d = CHECK;
        ack_d   = gnt_q;
      end
      CHECK: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = wrap_idx(32'(win_q), 32'd1);
        if (q_i != d_q) err_d = 1'b1;
      end
      CLEAR: begin
        state_d   = CLRCHK;
        clr_ack_d = 1'b1;
      end
      CLRCHK: begin
        state_d = IDLE;
        if (q_i != '0) err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      d_q       <= '0;
      srst_q    <= 1'b0;
      gnt_q     <= '0;
      ack_q     <= '0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      d_q       <= d_d;
      srst_q    <= srst_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      clr_ack_q <= clr_ack_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign d_o           = d_q;
  assign srst_o        = srst_q;
  assign bus.gnt_o     = gnt_q;
  assign bus.ack_o     = ack_q;
  assign bus.clr_ack_o = clr_ack_q;
  assign bus.busy_o    = busy_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Randomized and directed bench for dff_write_arbiter against a transaction-level model
// that expands each arbitration decision into its expected 3-cycle output waveform.
module tb_dff_write_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DW    = NREQ * WIDTH;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [WIDTH-1:0] q_i;
  logic [WIDTH-1:0] d_o;
  logic             srst_o;

  dff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  dff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus    (bus),
    .q_i    (q_i),
    .d_o    (d_o),
    .srst_o (srst_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared sync_reset register, with an optional stuck-at-zero readback fault
  logic [WIDTH-1:0] reg_q;
  logic             fault_op;
  always @(posedge clk_i) reg_q <= srst_o ? '0 : d_o;
  assign q_i = fault_op ? '0 : reg_q;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  ack;
    logic             clr_ack;
    logic             srst;
    logic             busy;
    logic             err;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t             exp_q[$];
  int unsigned      m_ptr;
  logic [WIDTH-1:0] m_d;
  logic             m_err;
  int               checks;
  int               failures;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
    end
  endtask

  task automatic push_exp(input logic [NREQ-1:0] gnt, input logic [NREQ-1:0] ack,
                          input logic clr_ack, input logic srst, input logic busy);
    exp_t e;
    e.gnt = gnt; e.ack = ack; e.clr_ack = clr_ack; e.srst = srst; e.busy = busy;
    e.err = m_err; e.d = m_d;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr = 0;
    m_d   = '0;
    m_err = 1'b0;
  endtask

  // One arbitration decision, expanded into the cycles that follow it
  task automatic decide(input logic [NREQ-1:0] req, input logic clr,
                        input logic [DW-1:0] wd, input logic flt);
    int               win;
    logic [NREQ-1:0]  oh;
    logic [WIDTH-1:0] seen;
    win = -1;
    if (clr) begin
      fault_op = flt;
      push_exp('0, '0, 1'b0, 1'b1, 1'b1);
      push_exp('0, '0, 1'b1, 1'b0, 1'b1);
      push_exp('0, '0, 1'b0, 1'b0, 1'b0);
    end else begin
      for (int i = 0; i < int'(NREQ); i++)
        if (win < 0 && req[(int'(m_ptr) + i) % int'(NREQ)]) win = (int'(m_ptr) + i) % int'(NREQ);
      if (win < 0) begin
        push_exp('0, '0, 1'b0, 1'b0, 1'b0);
      end else begin
        fault_op = flt;
        oh  = '0;
        oh[win] = 1'b1;
        m_d = wd[win*WIDTH +: WIDTH];
        push_exp(oh, '0, 1'b0, 1'b0, 1'b1);
        push_exp(oh, oh, 1'b0, 1'b0, 1'b1);
        seen = flt ? '0 : m_d;
        if (seen != m_d) m_err = 1'b1;
        push_exp('0, '0, 1'b0, 1'b0, 1'b0);
        m_ptr = (win + 1) % NREQ;
      end
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_val("gnt_o",     32'(bus.gnt_o),     32'(e.gnt));
    check_val("ack_o",     32'(bus.ack_o),     32'(e.ack));
    check_val("clr_ack_o", 32'(bus.clr_ack_o), 32'(e.clr_ack));
    check_val("srst_o",    32'(srst_o),        32'(e.srst));
    check_val("busy_o",    32'(bus.busy_o),    32'(e.busy));
    check_val("err_o",     32'(bus.err_o),     32'(e.err));
    check_val("d_o",       32'(d_o),           32'(e.d));
  endtask

  task automatic step(input logic [NREQ-1:0] req, input logic clr,
                      input logic [DW-1:0] wd, input logic flt);
    exp_t e;
    bus.req_i   = req;
    bus.clr_i   = clr;
    bus.wdata_i = wd;
    if (exp_q.size() == 0) decide(req, clr, wd, flt);
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check_outputs(e);
  endtask

  task automatic drain(input logic [DW-1:0] wd);
    while (exp_q.size() != 0) step('0, 1'b0, wd, 1'b0);
  endtask

  task automatic do_reset(input int cycles, input logic [NREQ-1:0] req);
    exp_t z;
    z.gnt = '0; z.ack = '0; z.clr_ack = 1'b0; z.srst = 1'b0; z.busy = 1'b0;
    z.err = 1'b0; z.d = '0;
    rst_i       = 1'b0;
    bus.req_i   = req;
    bus.clr_i   = 1'b0;
    bus.wdata_i = '0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i);
      #1;
      check_outputs(z);
    end
    rst_i = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] rq;
    logic            cl;
    logic [DW-1:0]   wd;
    checks   = 0;
    failures = 0;
    fault_op = 1'b0;
    rst_i    = 1'b0;

    // Reset held with all requesters active, then first grant to requester 0
    do_reset(3, 4'b1111);
    step(4'b1111, 1'b0, 32'h4433_2211, 1'b0);
    drain(32'h4433_2211);

    // Single write from requester 0
    step(4'b0001, 1'b0, 32'h0000_00A5, 1'b0);
    drain(32'h0000_00A5);

    // Round-robin from a fresh pointer
    do_reset(1, 4'b0000);
    for (int c = 0; c < 15; c++) step(4'b1111, 1'b0, 32'h4433_2211, 1'b0);
    drain(32'h4433_2211);

    // Clear wins over a simultaneous request, pointer untouched
    step(4'b0001, 1'b0, 32'h0000_005A, 1'b0);
    drain(32'h0000_005A);
    step(4'b0010, 1'b1, 32'h0000_7700, 1'b0);
    step(4'b0010, 1'b1, 32'h0000_7700, 1'b0);
    step(4'b0010, 1'b0, 32'h0000_7700, 1'b0);
    step(4'b0010, 1'b0, 32'h0000_7700, 1'b0);
    drain(32'h0000_7700);

    // Randomized traffic: level requests held until ack, clear dropped on clr_ack
    rq = '0;
    cl = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rq = rq | (NREQ'($urandom_range(0, 15)) & NREQ'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) == 0) rq = rq & NREQ'($urandom_range(0, 15));
      if (!cl && $urandom_range(0, 11) == 0) cl = 1'b1;
      wd = DW'($urandom);
      step(rq, cl, wd, 1'b0);
      rq = rq & ~bus.ack_o;
      if (bus.clr_ack_o) cl = 1'b0;
    end
    drain('0);

    // Readback fault: ack still pulses, err sticks across good writes
    step(4'b0100, 1'b0, 32'h003C_0000, 1'b1);
    drain(32'h003C_0000);
    for (int c = 0; c < 9; c++) step(4'b1111, 1'b0, 32'hC3B2_A190, 1'b0);
    drain(32'hC3B2_A190);

    // Async reset during GRANT: outputs drop before any clock edge, no ack
    step(4'b0010, 1'b0, 32'h0000_6600, 1'b0);
    drain(32'h0000_6600);
    step(4'b0100, 1'b0, 32'h0099_0000, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    check_val("async_gnt",  32'(bus.gnt_o),  32'd0);
    check_val("async_busy", 32'(bus.busy_o), 32'd0);
    check_val("async_err",  32'(bus.err_o),  32'd0);
    do_reset(2, 4'b0100);
    for (int c = 0; c < 6; c++) step(4'b1111, 1'b0, 32'h1357_9BDF, 1'b0);
    drain(32'h1357_9BDF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
